// File: rtl/stack_overlap_engine.sv
// Stacking-game overlap engine: intersects a dropped block with the previous block,
// snaps near-perfect drops, measures the overlap in block units and tracks the level.
module stack_overlap_engine #(
  parameter int unsigned COORD_W   = 9,
  parameter int unsigned SIZE_W    = 4,
  parameter int unsigned UNIT_PX   = 20,
  parameter int unsigned SNAP_TOL  = 2,
  parameter int unsigned MAX_LEVEL = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               new_game,
  input  logic [COORD_W-1:0] base_start,
  input  logic [COORD_W-1:0] base_end,
  input  logic               drop_valid,
  output logic               drop_ready,
  input  logic [COORD_W-1:0] curr_start,
  input  logic [COORD_W-1:0] curr_end,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               hit,
  output logic               perfect,
  output logic [COORD_W-1:0] inter_start,
  output logic [COORD_W-1:0] inter_end,
  output logic [SIZE_W-1:0]  inter_size,
  output logic [SIZE_W-1:0]  level,
  output logic               game_over
);

  localparam int unsigned DW = COORD_W + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] CALC  = 3'd2;
  localparam logic [2:0] SIZE  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [COORD_W-1:0] prev_s_q, prev_s_d, prev_e_q, prev_e_d;
  logic [COORD_W-1:0] cur_s_q, cur_s_d, cur_e_q, cur_e_d;
  logic [COORD_W-1:0] rs_q, rs_d, re_q, re_d;
  logic               perf_q, perf_d;
  logic [DW-1:0]      rem_q, rem_d;
  logic [SIZE_W-1:0]  cnt_q, cnt_d;
  logic               hit_q, hit_d, perfect_q, perfect_d;
  logic [COORD_W-1:0] inter_start_q, inter_start_d, inter_end_q, inter_end_d;
  logic [SIZE_W-1:0]  inter_size_q, inter_size_d, level_q, level_d, level_inc;

  logic [DW-1:0]      cs_x, ce_x, ps_x, pe_x, ds_abs, de_abs, width_c;
  logic [COORD_W-1:0] hi_c, lo_c, rs_c, re_c;
  logic               perfect_c, overlap_c;

  // Overlap arithmetic on the latched drop, all at COORD_W+1 bits.
  always_comb begin
    cs_x      = {1'b0, cur_s_q};
    ce_x      = {1'b0, cur_e_q};
    ps_x      = {1'b0, prev_s_q};
    pe_x      = {1'b0, prev_e_q};
    ds_abs    = (cs_x >= ps_x) ? cs_x - ps_x : ps_x - cs_x;
    de_abs    = (ce_x >= pe_x) ? ce_x - pe_x : pe_x - ce_x;
    perfect_c = (ds_abs <= DW'(SNAP_TOL)) && (de_abs <= DW'(SNAP_TOL));
    hi_c      = (cur_s_q < prev_s_q) ? cur_s_q : prev_s_q;
    lo_c      = (cur_e_q > prev_e_q) ? cur_e_q : prev_e_q;
    rs_c      = perfect_c ? prev_s_q : hi_c;
    re_c      = perfect_c ? prev_e_q : lo_c;
    overlap_c = (rs_c >= re_c);
    width_c   = {1'b0, rs_c} - {1'b0, re_c} + DW'(1);
  end

  always_comb begin
    state_d       = state_q;
    prev_s_d      = prev_s_q;
    prev_e_d      = prev_e_q;
    cur_s_d       = cur_s_q;
    cur_e_d       = cur_e_q;
    rs_d          = rs_q;
    re_d          = re_q;
    perf_d        = perf_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    hit_d         = hit_q;
    perfect_d     = perfect_q;
    inter_start_d = inter_start_q;
    inter_end_d   = inter_end_q;
    inter_size_d  = inter_size_q;
    level_d       = level_q;
    level_inc     = level_q + SIZE_W'(1);
    if (new_game) begin
      state_d  = READY;
      prev_s_d = base_start;
      prev_e_d = base_end;
      level_d  = '0;
    end else begin
      case (state_q)
        READY: if (drop_valid) begin
          cur_s_d = curr_start;
          cur_e_d = curr_end;
          state_d = CALC;
        end
        CALC: begin
          if (!overlap_c) begin
            hit_d         = 1'b0;
            perfect_d     = 1'b0;
            inter_start_d = '0;
            inter_end_d   = '0;
            inter_size_d  = '0;
            state_d       = RESP;
          end else begin
            rs_d    = rs_c;
            re_d    = re_c;
            perf_d  = perfect_c;
            rem_d   = width_c;
            cnt_d   = '0;
            state_d = SIZE;
          end
        end
        // Result outputs are only loaded on entry to RESP so they hold while not valid.
        SIZE: begin
          if (rem_q >= DW'(UNIT_PX)) begin
            rem_d = rem_q - DW'(UNIT_PX);
            if (cnt_q != '1) cnt_d = cnt_q + SIZE_W'(1);
          end else begin
            hit_d         = (cnt_q != '0);
            perfect_d     = perf_q;
            inter_start_d = rs_q;
            inter_end_d   = re_q;
            inter_size_d  = cnt_q;
            state_d       = RESP;
          end
        end
        RESP: if (res_ready) begin
          if (hit_q) begin
            prev_s_d = inter_start_q;
            prev_e_d = inter_end_q;
            level_d  = level_inc;
            state_d  = (level_inc == SIZE_W'(MAX_LEVEL)) ? OVER : READY;
          end else begin
            state_d = OVER;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      prev_s_q      <= '0;
      prev_e_q      <= '0;
      cur_s_q       <= '0;
      cur_e_q       <= '0;
      rs_q          <= '0;
      re_q          <= '0;
      perf_q        <= 1'b0;
      rem_q         <= '0;
      cnt_q         <= '0;
      hit_q         <= 1'b0;
      perfect_q     <= 1'b0;
      inter_start_q <= '0;
      inter_end_q   <= '0;
      inter_size_q  <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      prev_s_q      <= prev_s_d;
      prev_e_q      <= prev_e_d;
      cur_s_q       <= cur_s_d;
      cur_e_q       <= cur_e_d;
      rs_q          <= rs_d;
      re_q          <= re_d;
      perf_q        <= perf_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      hit_q         <= hit_d;
      perfect_q     <= perfect_d;
      inter_start_q <= inter_start_d;
      inter_end_q   <= inter_end_d;
      inter_size_q  <= inter_size_d;
      level_q       <= level_d;
    end
  end

  assign drop_ready  = (state_q == READY);
  assign res_valid   = (state_q == RESP);
  assign game_over   = (state_q == OVER);
  assign hit         = hit_q;
  assign perfect     = perfect_q;
  assign inter_start = inter_start_q;
  assign inter_end   = inter_end_q;
  assign inter_size  = inter_size_q;
  assign level       = level_q;

endmodule

// File: tb/tb_stack_overlap_engine.sv
// Bench for stack_overlap_engine: directed scenarios plus randomized drops
// compared against an interval-arithmetic model of the game.
module tb_stack_overlap_engine;

  localparam int COORD_W = 9;
  localparam int SIZE_W  = 4;
  localparam int UNIT    = 20;
  localparam int TOL     = 2;
  localparam int MAXLVL  = 15;

  logic               clk = 1'b0;
  logic               resetn, new_game, drop_valid, res_ready;
  logic [COORD_W-1:0] base_start, base_end, curr_start, curr_end;
  logic               drop_ready, res_valid, hit, perfect, game_over;
  logic [COORD_W-1:0] inter_start, inter_end;
  logic [SIZE_W-1:0]  inter_size, level;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_ps, m_pe, m_level;
  bit m_over;

  stack_overlap_engine #(
    .COORD_W(COORD_W), .SIZE_W(SIZE_W), .UNIT_PX(UNIT), .SNAP_TOL(TOL), .MAX_LEVEL(MAXLVL)
  ) dut (
    .clk(clk), .resetn(resetn), .new_game(new_game),
    .base_start(base_start), .base_end(base_end),
    .drop_valid(drop_valid), .drop_ready(drop_ready),
    .curr_start(curr_start), .curr_end(curr_end),
    .res_valid(res_valid), .res_ready(res_ready),
    .hit(hit), .perfect(perfect),
    .inter_start(inter_start), .inter_end(inter_end), .inter_size(inter_size),
    .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input int cs, input int ce,
                       output int eh, output int ep, output int es, output int ee,
                       output int esz, output int elat);
    int w;
    ep = (iabs(cs - m_ps) <= TOL) && (iabs(ce - m_pe) <= TOL);
    if (ep) begin
      es = m_ps; ee = m_pe;
    end else begin
      es = (cs < m_ps) ? cs : m_ps;
      ee = (ce > m_pe) ? ce : m_pe;
    end
    if (es < ee) begin
      eh = 0; ep = 0; es = 0; ee = 0; esz = 0; elat = 1;
    end else begin
      w    = es - ee + 1;
      esz  = (w / UNIT > 15) ? 15 : w / UNIT;
      eh   = (esz > 0);
      elat = w / UNIT + 2;
    end
  endtask

  task automatic start_game(input int bs, input int be);
    new_game = 1'b1; base_start = bs[COORD_W-1:0]; base_end = be[COORD_W-1:0];
    @(posedge clk); #1;
    new_game = 1'b0;
    m_ps = bs; m_pe = be; m_level = 0; m_over = 0;
    check("ng_drop_ready", drop_ready, 1);
    check("ng_level", level, 0);
    check("ng_game_over", game_over, 0);
  endtask

  task automatic do_drop(input int cs, input int ce, input int bp);
    int eh, ep, es, ee, esz, elat, lat;
    model(cs, ce, eh, ep, es, ee, esz, elat);
    check("pre_drop_ready", drop_ready, 1);
    curr_start = cs[COORD_W-1:0]; curr_end = ce[COORD_W-1:0]; drop_valid = 1'b1;
    @(posedge clk); #1;
    drop_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    for (int i = 0; i <= bp; i++) begin
      check("res_valid", res_valid, 1);
      check("hit", hit, eh);
      check("perfect", perfect, ep);
      check("inter_start", inter_start, es);
      check("inter_end", inter_end, ee);
      check("inter_size", inter_size, esz);
      if (i < bp) begin @(posedge clk); #1; end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (eh) begin
      m_ps = es; m_pe = ee; m_level++;
      if (m_level == MAXLVL) m_over = 1;
    end else begin
      m_over = 1;
    end
    check("post_res_valid", res_valid, 0);
    check("post_level", level, m_level);
    check("post_game_over", game_over, int'(m_over));
    check("post_drop_ready", drop_ready, int'(!m_over));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drop_ready"}, drop_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_perfect"}, perfect, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_inter_start"}, inter_start, 0);
    check({tag, "_inter_end"}, inter_end, 0);
    check({tag, "_inter_size"}, inter_size, 0);
  endtask

  initial begin
    int cs, ce, bs, be;
    resetn = 1'b0; new_game = 1'b0; drop_valid = 1'b0; res_ready = 1'b0;
    base_start = '0; base_end = '0; curr_start = '0; curr_end = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_drop_ready", drop_ready, 0);

    // partial overlap
    start_game(199, 100);
    do_drop(219, 120, 0);
    // snap with backpressure
    do_drop(201, 122, 5);
    // miss, then ignored drops in OVER
    do_drop(99, 0, 0);
    drop_valid = 1'b1; curr_start = 9'd199; curr_end = 9'd120;
    repeat (3) begin
      @(posedge clk); #1;
      check("over_drop_ready", drop_ready, 0);
      check("over_res_valid", res_valid, 0);
      check("over_game_over", game_over, 1);
    end
    drop_valid = 1'b0;

    // sub-unit sliver
    start_game(199, 120);
    do_drop(250, 190, 0);

    // abort during SIZE
    start_game(199, 100);
    curr_start = 9'd199; curr_end = 9'd100; drop_valid = 1'b1;
    @(posedge clk); #1;
    drop_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_res_valid_before", res_valid, 0);
    start_game(300, 200);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_result", res_valid, 0);
      @(posedge clk); #1;
    end
    check("abort_level", level, 0);
    do_drop(310, 200, 0);

    // full stack of perfect drops
    start_game(199, 100);
    for (int i = 0; i < MAXLVL; i++) do_drop(199, 100, 0);
    check("stack_level", level, 15);
    check("stack_over", game_over, 1);

    // reset in mid-operation
    start_game(199, 100);
    do_drop(199, 100, 0);
    curr_start = 9'd199; curr_end = 9'd100; drop_valid = 1'b1;
    @(posedge clk); #1;
    drop_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check_all_zero("midreset");

    // randomized play
    m_over = 1;
    for (int n = 0; n < 300; n++) begin
      if (m_over) begin
        bs = int'($urandom_range(150, 511));
        be = bs - int'($urandom_range(20, 150));
        start_game(bs, be);
      end
      cs = m_ps + int'($urandom_range(0, 60)) - 30;
      if (cs > 511) cs = 511;
      if (cs < 0) cs = 0;
      ce = m_pe + int'($urandom_range(0, 60)) - 30;
      if (ce < 0) ce = 0;
      if (ce > cs) ce = cs;
      if ($urandom_range(0, 3) == 0) begin
        cs = m_ps + int'($urandom_range(0, 4)) - 2;
        ce = m_pe + int'($urandom_range(0, 4)) - 2;
        if (cs > 511) cs = 511;
        if (ce < 0) ce = 0;
      end
      do_drop(cs, ce, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_overlap_engine.md
STACK_OVERLAP_ENGINE -- requirements
Module: stack_overlap_engine

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  COORD_W, 9, pixel coordinate width
  SIZE_W, 4, block size width, in units
  UNIT_PX, 20, pixels per block unit
  SNAP_TOL, 2, maximum pixel misalignment still treated as a perfect stack
  MAX_LEVEL, 15, level at which the stack is complete
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  clock
  resetn  in  1  synchronous active-low reset
  new_game  in  1  pulse; loads the base block
  base_start  in  COORD_W  base block high edge
  base_end  in  COORD_W  base block low edge
  drop_valid  in  1  dropped block offered
  drop_ready  out  1  engine accepts a drop
  curr_start  in  COORD_W  dropped block high edge
  curr_end  in  COORD_W  dropped block low edge
  res_valid  out  1  result available
  res_ready  in  1  consumer takes the result
  hit  out  1  overlap of at least one unit
  perfect  out  1  snapped within SNAP_TOL
  inter_start  out  COORD_W  resulting block high edge
  inter_end  out  COORD_W  resulting block low edge
  inter_size  out  SIZE_W  resulting size in units
  level  out  SIZE_W  blocks successfully stacked
  game_over  out  1  miss, or level reached MAX_LEVEL
REQ-003 Reset SHALL be resetn: synchronous, active-low. Clock SHALL be clk, with all state updated on its rising edge.

Function
REQ-004 A block SHALL occupy pixels end..start inclusive, with start >= end; width = start-end+1.
REQ-005 The FSM SHALL have the states IDLE, READY, CALC, SIZE, RESP and OVER.
REQ-006 IDLE: drop_ready=0; new_game SHALL load the stored prev block from base_start/base_end, clear level and game_over, and go to READY.
REQ-007 new_game SHALL have the same effect in every state except during reset, SHALL take priority over all other events, and SHALL abort any calculation in progress with res_valid dropping the next cycle.
REQ-008 READY: drop_ready=1; drop_valid&drop_ready SHALL latch curr_start/curr_end and go to CALC.
REQ-009 CALC (1 cycle): hi=min(curr_start,prev_start), lo=max(curr_end,prev_end).
  - perfect=1 if |curr_start-prev_start|<=SNAP_TOL and |curr_end-prev_end|<=SNAP_TOL; the result is then prev_start/prev_end.
  - Otherwise, if hi>=lo, the result is hi/lo.
  - If hi<lo: hit=0, inter_start=inter_end=0, inter_size=0, go to RESP.
  - Else load rem=result width, clear the size counter, go to SIZE.
REQ-010 SIZE: each cycle with rem>=UNIT_PX SHALL apply rem-=UNIT_PX and increment size, saturating at 2^SIZE_W-1; when rem<UNIT_PX go to RESP.
REQ-011 hit SHALL be 1 only if the computed size is nonzero; an overlap narrower than UNIT_PX is a miss, with inter_start/inter_end still reported.
REQ-012 Latency from the accepting edge to res_valid=1 SHALL be 1 cycle for a miss in CALC, and size+2 cycles otherwise.
REQ-013 RESP: res_valid=1 and all result outputs SHALL hold stable until res_ready=1.
REQ-014 On the RESP handshake with hit=1:
  - prev SHALL take inter_start/inter_end.
  - level SHALL increment.
  - If the new level equals MAX_LEVEL go to OVER, else go to READY.
REQ-015 On the RESP handshake with hit=0: go to OVER; level SHALL be unchanged.
REQ-016 OVER: game_over=1 and drop_ready=0 SHALL hold until new_game; drop_valid SHALL be ignored.
REQ-017 All subtractions SHALL be unsigned at COORD_W+1 bits; widths SHALL never wrap.
REQ-018 hit, perfect, inter_* SHALL be valid only while res_valid=1 and SHALL otherwise hold their last values.

Reset
REQ-019 When resetn=0 at an edge: state=IDLE; drop_ready, res_valid, hit, perfect, game_over, level, inter_start, inter_end, inter_size and prev SHALL all be 0.
REQ-020 Reset SHALL take priority over new_game and over any handshake, including in mid-operation states.

Verification
REQ-021 Partial overlap: with UNIT_PX=20, base [199,100], drop [219,120] -> hit=1, perfect=0, inter [199,120], size=4, res_valid 6 cycles after acceptance, level=1 after handshake.
REQ-022 Snap: prev [199,120], drop [201,122] -> perfect=1, inter [199,120], size=4.
REQ-023 Miss and game over:
  - prev [199,120], drop [99,0] -> hit=0, size=0, res_valid 1 cycle after acceptance.
  - After handshake: game_over=1, drop_ready=0.
  - Further drop_valid is ignored.
REQ-024 Sub-unit sliver: prev [199,120], drop [250,190] -> width 10, size=0, hit=0, game_over after handshake.
REQ-025 Backpressure and abort:
  - Hold res_ready=0 for 5 cycles -> outputs stable throughout.
  - new_game asserted during SIZE -> READY with level=0 next cycle and no result delivered.
REQ-026 Full stack and reset:
  - 15 perfect drops -> level=15, game_over=1.
  - resetn=0 in any state -> all outputs 0 after one edge.
